half_word_packer: RTL and testbench

HALF_WORD_PACKER -- requirements
Module: half_word_packer

---
 rtl/half_word_packer_pkg.sv | 14 +
 rtl/half_word_packer.sv | 133 +++++++++++++
 tb/tb_half_word_packer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/half_word_packer_pkg.sv
// Shared types and constants for the half-word packer.
package half_word_packer_pkg;

  // Packing phase: LOW expects the low half next, HIGH holds a low half
  // and expects its high partner.
  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } pack_state_t;

  // Value each half of a packed word is compared against for dout_flags.
  localparam int unsigned FLAG_CMP_VAL = 1;

endpackage

// File: rtl/half_word_packer.sv
// Packs pairs of half-words (low first, then high) into full words behind a
// one-entry output register with valid/ready handshakes on both sides.
// A half marked din_last while no low half is held is emitted alone as
// {0, half}. Optional build macro HALF_WORD_PACKER_FLAGS_EN adds dout_flags
// = {high==1, low==1}, registered alongside dout_data.
module half_word_packer
  import half_word_packer_pkg::*;
#(
  parameter int HALF_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [HALF_W-1:0]   din_data,
  input  logic                din_last,
  input  logic                din_vld,
  output logic                din_rd,
  output logic [2*HALF_W-1:0] dout_data,
  output logic                dout_vld,
`ifdef HALF_WORD_PACKER_FLAGS_EN
  output logic [1:0]          dout_flags,
`endif
  input  logic                dout_rd,
  output logic [CNT_W-1:0]    word_cnt
);

  pack_state_t          r_state;
  pack_state_t          w_state_next;
  logic [HALF_W-1:0]    r_low;
  logic [2*HALF_W-1:0]  r_dout_data;
  logic                 r_dout_vld;
  logic [CNT_W-1:0]     r_word_cnt;

  logic                 w_out_free;
  logic                 w_din_rd;
  logic                 w_load;
  logic                 w_low_wr;
  logic [2*HALF_W-1:0]  w_load_data;
  logic                 w_xfer;

  // Output register can take a new word when empty or being drained now.
  assign w_out_free = !r_dout_vld || dout_rd;
  assign w_xfer     = r_dout_vld && dout_rd;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_LOW;
    else        r_state <= w_state_next;
  end

  // Next-state, input ready and output-load decode.
  always_comb begin
    w_state_next = r_state;
    w_din_rd     = 1'b0;
    w_load       = 1'b0;
    w_low_wr     = 1'b0;
    w_load_data  = '0;
    case (r_state)
      ST_LOW: begin
        // A lone last half goes straight to the output, so it needs room.
        w_din_rd = din_last ? w_out_free : 1'b1;
        if (din_vld && w_din_rd) begin
          if (din_last) begin
            w_load      = 1'b1;
            w_load_data = {{HALF_W{1'b0}}, din_data};
          end else begin
            w_low_wr     = 1'b1;
            w_state_next = ST_HIGH;
          end
        end
      end
      ST_HIGH: begin
        // din_last on the high half carries no packing meaning.
        w_din_rd = w_out_free;
        if (din_vld && w_din_rd) begin
          w_load       = 1'b1;
          w_load_data  = {din_data, r_low};
          w_state_next = ST_LOW;
        end
      end
      default: w_state_next = ST_LOW;
    endcase
  end

  // Nothing is accepted while reset is held.
  assign din_rd = rst_n && w_din_rd;

  // Low-half holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_low <= '0;
    else if (w_low_wr) r_low <= din_data;
  end

  // Output register: load wins over drain so back-to-back words need no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout_data <= '0;
      r_dout_vld  <= 1'b0;
    end else if (w_load) begin
      r_dout_data <= w_load_data;
      r_dout_vld  <= 1'b1;
    end else if (w_xfer) begin
      r_dout_vld  <= 1'b0;
    end
  end

  // Count of words handed to the consumer, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_word_cnt <= '0;
    else if (w_xfer) r_word_cnt <= r_word_cnt + CNT_W'(1);
  end

  assign dout_data = r_dout_data;
  assign dout_vld  = r_dout_vld;
  assign word_cnt  = r_word_cnt;

`ifdef HALF_WORD_PACKER_FLAGS_EN
  logic [1:0] r_dout_flags;

  // Per-half "equals one" flags captured with the word they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout_flags <= 2'b00;
    end else if (w_load) begin
      r_dout_flags <= {w_load_data[2*HALF_W-1:HALF_W] == HALF_W'(FLAG_CMP_VAL),
                       w_load_data[HALF_W-1:0]        == HALF_W'(FLAG_CMP_VAL)};
    end
  end

  assign dout_flags = r_dout_flags;
`endif

endmodule

// File: tb/tb_half_word_packer.sv
// Self-checking bench for half_word_packer: directed scenarios plus random
// handshakes against a behavioural reference model.
module tb_half_word_packer;

  localparam int HW = 16;
  localparam int CW = 2;

  logic            clk;
  logic            rst_n;
  logic [HW-1:0]   din_data;
  logic            din_last;
  logic            din_vld;
  logic            din_rd;
  logic [2*HW-1:0] dout_data;
  logic            dout_vld;
  logic            dout_rd;
  logic [CW-1:0]   word_cnt;
`ifdef HALF_WORD_PACKER_FLAGS_EN
  logic [1:0]      dout_flags;
`endif

  half_word_packer #(.HALF_W(HW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_data  (din_data),
    .din_last  (din_last),
    .din_vld   (din_vld),
    .din_rd    (din_rd),
    .dout_data (dout_data),
    .dout_vld  (dout_vld),
`ifdef HALF_WORD_PACKER_FLAGS_EN
    .dout_flags(dout_flags),
`endif
    .dout_rd   (dout_rd),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  // Reference model: is a low half pending, what is in the output slot,
  // how many words have left.
  bit            m_pend;
  logic [HW-1:0] m_low;
  bit            m_vld;
  logic [31:0]   m_data;
  int            m_cnt;
  logic [1:0]    m_flags;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend  = 0;
    m_low   = '0;
    m_vld   = 0;
    m_data  = '0;
    m_cnt   = 0;
    m_flags = 2'b00;
  endtask

  // One clock: check outputs at the falling edge, then advance the model
  // with the inputs present at the rising edge.
  task automatic cycle();
    bit free, exp_rd, acc, xfer, load;
    logic [31:0] nw;
    @(negedge clk);
    if (!rst_n) model_reset();
    free   = !m_vld || dout_rd;
    exp_rd = !rst_n ? 1'b0 : (m_pend ? free : (din_last ? free : 1'b1));
    check("din_rd", 64'(din_rd), 64'(exp_rd));
    check("dout_vld", 64'(dout_vld), 64'(m_vld));
    check("dout_data", 64'(dout_data), 64'(m_data));
    check("word_cnt", 64'(word_cnt), 64'(m_cnt % (1 << CW)));
`ifdef HALF_WORD_PACKER_FLAGS_EN
    check("dout_flags", 64'(dout_flags), 64'(m_flags));
`endif
    if (dout_vld && dout_rd) xfers++;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      acc  = din_vld && exp_rd;
      xfer = m_vld && dout_rd;
      load = 0;
      nw   = '0;
      if (acc) begin
        if (m_pend) begin
          nw = {din_data, m_low};
          load = 1;
          m_pend = 0;
        end else if (din_last) begin
          nw = {16'h0000, din_data};
          load = 1;
        end else begin
          m_low = din_data;
          m_pend = 1;
        end
      end
      if (xfer) m_cnt = m_cnt + 1;
      if (load) begin
        m_vld   = 1;
        m_data  = nw;
        m_flags = {nw[31:16] == 16'd1, nw[15:0] == 16'd1};
      end else if (xfer) begin
        m_vld = 0;
      end
    end
    #1;
  endtask

  task automatic half(input logic [HW-1:0] d, input logic last);
    din_data = d;
    din_last = last;
    din_vld  = 1'b1;
    cycle();
    din_vld  = 1'b0;
    din_last = 1'b0;
  endtask

  task automatic idle(input int n);
    din_vld = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    din_data = '0;
    din_last = 1'b0;
    din_vld  = 1'b0;
    dout_rd  = 1'b0;
    model_reset();
    idle(2);
    check("rst_vld", 64'(dout_vld), 64'd0);
    check("rst_cnt", 64'(word_cnt), 64'd0);
    check("rst_rd", 64'(din_rd), 64'd0);
    rst_n = 1'b1;

    // Basic pair, flags case.
    dout_rd = 1'b1;
    half(16'h0001, 1'b0);
    half(16'h0001, 1'b0);
    check("pair_vld", 64'(dout_vld), 64'd1);
    check("pair_data", 64'(dout_data), 64'h0001_0001);
`ifdef HALF_WORD_PACKER_FLAGS_EN
    check("pair_flags", 64'(dout_flags), 64'd3);
`endif
    idle(1);
    check("pair_cnt", 64'(word_cnt), 64'd1);
    $display("pair 0x0001/0x0001 done");

    // Backpressure: output held, HIGH state stalls input.
    dout_rd = 1'b0;
    half(16'hBEEF, 1'b0);
    half(16'hDEAD, 1'b0);
    half(16'h1111, 1'b0);
    din_data = 16'h2222;
    din_vld  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_rd", 64'(din_rd), 64'd0);
      check("stall_data", 64'(dout_data), 64'hDEAD_BEEF);
      check("stall_vld", 64'(dout_vld), 64'd1);
    end
    dout_rd = 1'b1;
    cycle();
    check("release_data", 64'(dout_data), 64'h2222_1111);
    idle(1);
    $display("backpressure 0xDEADBEEF done");

    // Lone last half stays in LOW.
    half(16'h1234, 1'b1);
    check("last_data", 64'(dout_data), 64'h0000_1234);
    half(16'h5555, 1'b0);
    check("last_low_vld", 64'(dout_vld), 64'd0);
    half(16'h6666, 1'b0);
    check("last_next_data", 64'(dout_data), 64'h6666_5555);
    idle(1);
    $display("last-only 0x1234 done");

    // Streaming: 8 halves back to back.
    xfers = 0;
    din_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din_data = 16'($urandom);
      cycle();
    end
    din_vld = 1'b0;
    cycle();
    check("stream_words", 64'(xfers), 64'd4);
    $display("stream 8 halves done");

    // Reset mid-packet discards the held low half.
    half(16'h0AAA, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("midrst_vld", 64'(dout_vld), 64'd0);
    check("midrst_cnt", 64'(word_cnt), 64'd0);
    half(16'h0002, 1'b0);
    half(16'h0003, 1'b0);
    check("midrst_data", 64'(dout_data), 64'h0003_0002);
    idle(1);
    $display("mid-packet reset done");

    // Counter wrap with a 2-bit counter.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      half(16'(2 * i), 1'b0);
      half(16'(2 * i + 1), 1'b0);
    end
    idle(1);
    check("wrap_cnt", 64'(word_cnt), 64'd1);
    $display("counter wrap done");

    // Random handshakes.
    for (int i = 0; i < 1500; i++) begin
      din_vld  = ($urandom_range(0, 3) != 0);
      din_last = ($urandom_range(0, 3) == 0);
      din_data = ($urandom_range(0, 3) == 0) ? 16'd1 : 16'($urandom);
      dout_rd  = ($urandom_range(0, 2) != 0);
      rst_n    = ($urandom_range(0, 299) != 0);
      cycle();
      rst_n = 1'b1;
    end
    din_vld = 1'b0;
    $display("random run done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
